// File: rtl/johnson_counter_n.sv
// Johnson (twisted-ring) counter of WIDTH flip-flops with bidirectional stepping,
// synchronous load, one-cycle self-correction of illegal states and a phase decoder.
module johnson_counter_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           dir,
  input  logic                           load,
  input  logic [WIDTH-1:0]               load_value,
  output logic [WIDTH-1:0]               q,
  output logic [$clog2(2*WIDTH)-1:0]     phase,
  output logic                           wrap,
  output logic                           illegal
);

  localparam int unsigned PW = $clog2(2*WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [PW-1:0]    w_phase;
  logic             w_illegal;
  logic [WIDTH-1:0] w_next;

  // Phase k: k low ones for k in 1..WIDTH, then ones migrate toward the MSB.
  function automatic logic [WIDTH-1:0] legal_pattern(input int unsigned k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if ((k >= 1 && k <= WIDTH && b < k) || (k > WIDTH && b >= k - WIDTH))
        p[b] = 1'b1;
    end
    return p;
  endfunction

  always_comb begin
    w_phase   = '0;
    w_illegal = 1'b1;
    for (int unsigned k = 0; k < 2*WIDTH; k++) begin
      if (r_q == legal_pattern(k)) begin
        w_phase   = PW'(k);
        w_illegal = 1'b0;
      end
    end
  end

  always_comb begin
    w_next = '0;
    if (dir) w_next = {~r_q[0], r_q[WIDTH-1:1]};
    else     w_next = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= load_value;
      r_wrap <= 1'b0;
    end else if (w_illegal) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      // Only phase 2W-1 forward or phase 1 reverse step into all-zeros.
      r_q    <= w_next;
      r_wrap <= (w_next == '0);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q       = r_q;
  assign wrap    = r_wrap;
  assign phase   = w_phase;
  assign illegal = w_illegal;

endmodule

// File: tb/tb_johnson_counter_n.sv
// Scoreboard bench for johnson_counter_n: a WIDTH=4 and a WIDTH=8 instance run side by side
// against an arithmetic phase-index model.
module tb_johnson_counter_n;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_en = 0, a_dir = 0, a_load = 0;
  logic [3:0] a_lv = '0;
  logic [3:0] a_q;
  logic [2:0] a_phase;
  logic       a_wrap, a_illegal;

  logic       b_en = 0, b_dir = 0, b_load = 0;
  logic [7:0] b_lv = '0;
  logic [7:0] b_q;
  logic [3:0] b_phase;
  logic       b_wrap, b_illegal;

  johnson_counter_n #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(a_en), .dir(a_dir), .load(a_load), .load_value(a_lv),
    .q(a_q), .phase(a_phase), .wrap(a_wrap), .illegal(a_illegal));

  johnson_counter_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(b_en), .dir(b_dir), .load(b_load), .load_value(b_lv),
    .q(b_q), .phase(b_phase), .wrap(b_wrap), .illegal(b_illegal));

  typedef struct {
    string       tag;
    logic [15:0] q;
    int unsigned ph;
    logic        wr;
    logic        il;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] mq[2];
  logic        mw[2];
  int unsigned mwid[2] = '{4, 8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int unsigned k, input int unsigned w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 1);
    if (k == 0) return '0;
    if (k <= w) return 16'((32'd1 << k) - 1);
    return m & ~16'((32'd1 << (k - w)) - 1);
  endfunction

  function automatic bit legal(input logic [15:0] v, input int unsigned w);
    logic [15:0] m, c;
    m = 16'((32'd1 << w) - 1);
    c = ~v & m;
    return (v == 0) || ((v & (v + 16'd1)) == 0) || ((c & (c + 16'd1)) == 0);
  endfunction

  function automatic int unsigned phase_of(input logic [15:0] v, input int unsigned w);
    if (!legal(v, w) || v == 0) return 0;
    if (v[0]) return $countones(v);
    return 2*w - $countones(v);
  endfunction

  function automatic void model_step(input int i, input logic en, input logic dir,
                                     input logic ld, input logic [15:0] lv);
    int unsigned w, p, np;
    w = mwid[i];
    if (ld) begin
      mq[i] = lv; mw[i] = 1'b0;
    end else if (!legal(mq[i], w)) begin
      mq[i] = '0; mw[i] = 1'b0;
    end else if (en) begin
      p  = phase_of(mq[i], w);
      np = dir ? (p + 2*w - 1) % (2*w) : (p + 1) % (2*w);
      mq[i] = pat(np, w);
      mw[i] = (np == 0);
    end else begin
      mw[i] = 1'b0;
    end
  endfunction

  task automatic push_exp(input string tag);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.tag = $sformatf("%s/w%0d", tag, mwid[i]);
      e.q   = mq[i];
      e.ph  = phase_of(mq[i], mwid[i]);
      e.wr  = mw[i];
      e.il  = !legal(mq[i], mwid[i]);
      sb.push_back(e);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      if (i == 0) begin
        check({e.tag, ".q"},   32'(a_q),       32'(e.q));
        check({e.tag, ".ph"},  32'(a_phase),   e.ph);
        check({e.tag, ".wr"},  32'(a_wrap),    32'(e.wr));
        check({e.tag, ".il"},  32'(a_illegal), 32'(e.il));
      end else begin
        check({e.tag, ".q"},   32'(b_q),       32'(e.q));
        check({e.tag, ".ph"},  32'(b_phase),   e.ph);
        check({e.tag, ".wr"},  32'(b_wrap),    32'(e.wr));
        check({e.tag, ".il"},  32'(b_illegal), 32'(e.il));
      end
    end
  endtask

  // Called #1 after a rising edge; inputs already set for the coming edge.
  task automatic cyc(input string tag);
    model_step(0, a_en, a_dir, a_load, 16'(a_lv));
    model_step(1, b_en, b_dir, b_load, 16'(b_lv));
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Asynchronous reset asserted mid-cycle with load forced high to show reset wins.
  task automatic reset_pulse(input string tag);
    #2;
    reset  = 1'b1;
    a_load = 1'b1; a_lv = 4'h9;
    b_load = 1'b1; b_lv = 8'h5A;
    mq[0] = '0; mq[1] = '0; mw[0] = 1'b0; mw[1] = 1'b0;
    #1;
    push_exp({tag, "_async"});
    pop_check();
    @(posedge clk);
    #1;
    push_exp({tag, "_held"});
    pop_check();
    reset  = 1'b0;
    a_load = 1'b0;
    b_load = 1'b0;
  endtask

  initial begin
    mq[0] = '0; mq[1] = '0; mw[0] = 1'b0; mw[1] = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse("rst0");

    a_en = 1; a_dir = 0; b_en = 1; b_dir = 0;
    for (int i = 0; i < 9; i++) cyc("fwd");

    a_dir = 1; b_dir = 1;
    cyc("rev_to0");
    for (int i = 0; i < 8; i++) cyc("rev");

    a_dir = 0; b_dir = 0;
    for (int i = 0; i < 3; i++) cyc("to7");
    a_en = 0; b_en = 0;
    for (int i = 0; i < 3; i++) cyc("hold");
    a_en = 1; b_en = 1;
    for (int i = 0; i < 3; i++) begin
      a_dir = (i % 2 == 1); b_dir = a_dir;
      cyc("dirtog");
    end

    a_load = 1; a_lv = 4'h5; b_load = 1; b_lv = 8'h5A;
    cyc("ld_illegal");
    a_load = 0; b_load = 0; a_en = 0; b_en = 0;
    cyc("correct");

    a_en = 1; b_en = 1; a_dir = 0; b_dir = 0;
    cyc("to1");
    cyc("to3");
    a_load = 1; a_lv = 4'hC; b_load = 1; b_lv = 8'hF0;
    cyc("ld_wins");
    a_load = 0; b_load = 0;
    cyc("after_ld");

    reset_pulse("rst1");
    a_en = 1; a_dir = 0; b_en = 1; b_dir = 0;
    for (int i = 0; i < 16; i++) cyc("w8_fwd");
    for (int i = 0; i < 5; i++) cyc("midrun");
    reset_pulse("rst_mid");
    a_dir = 0; b_dir = 1;
    cyc("post_rst");

    for (int i = 0; i < 60; i++) begin
      a_en = 1'($urandom); a_dir = 1'($urandom);
      b_en = 1'($urandom); b_dir = 1'($urandom);
      a_load = ($urandom_range(0, 7) == 0); a_lv = 4'($urandom);
      b_load = ($urandom_range(0, 7) == 0); b_lv = 8'($urandom);
      cyc("rand");
    end
    a_load = 0; b_load = 0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
